// File: rtl/sky130_ef_sc_hd__pwrseq_ctrl_if.sv
// Request/dwell inputs and switch/isolation outputs between the block power
// manager (master) and the staged power-switch sequencer (slave).
interface sky130_ef_sc_hd__pwrseq_ctrl_if #(
    parameter int unsigned NSTAGES = 8,
    parameter int unsigned DLY_W   = 8
);
    logic               REQ;
    logic [DLY_W-1:0]   DLY;
    logic [NSTAGES-1:0] EN;
    logic               ISO;
    logic               ACK;
    logic               BUSY;

    modport master (
        output REQ,
        output DLY,
        input  EN,
        input  ISO,
        input  ACK,
        input  BUSY
    );

    modport slave (
        input  REQ,
        input  DLY,
        output EN,
        output ISO,
        output ACK,
        output BUSY
    );
endinterface

// File: rtl/sky130_ef_sc_hd__pwrseq_ctrl.sv
// Staged header-switch sequencer: turns segments on one at a time (EN[0]
// first) and off in reverse, holding isolation until the region is fully on.
// NSTAGES must lie in 2..32.
module sky130_ef_sc_hd__pwrseq_ctrl #(
    parameter int unsigned NSTAGES = 8,
    parameter int unsigned DLY_W   = 8
) (
    input  logic                            CLK,
    input  logic                            RESET,
    sky130_ef_sc_hd__pwrseq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        StOff,
        StUp,
        StDn,
        StOn
    } state_t;

    state_t             state;
    logic [NSTAGES-1:0] en;
    logic               iso;
    logic               ack;
    logic               busy;
    logic [DLY_W-1:0]   cnt;

    logic [DLY_W-1:0]   dwell;
    logic               expire;

    // A dwell of zero is treated as one cycle; expiry is the edge where cnt is 1.
    assign dwell  = (bus.DLY == '0) ? DLY_W'(1) : bus.DLY;
    assign expire = (cnt == DLY_W'(1));

    // Sequencer FSM with registered outputs; a reversal always wins over a stage event.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= StOff;
            en    <= '0;
            iso   <= 1'b1;
            ack   <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                StOff: begin
                    if (bus.REQ) begin
                        state <= StUp;
                        en    <= NSTAGES'(1);
                        busy  <= 1'b1;
                        cnt   <= dwell;
                    end
                end
                StUp: begin
                    if (!bus.REQ) begin
                        state <= StDn;
                        cnt   <= dwell;
                    end else if (expire) begin
                        if (&en) begin
                            state <= StOn;
                            ack   <= 1'b1;
                            iso   <= 1'b0;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            en  <= {en[NSTAGES-2:0], 1'b1};
                            cnt <= dwell;
                        end
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                StOn: begin
                    if (!bus.REQ) begin
                        state <= StDn;
                        iso   <= 1'b1;
                        ack   <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= dwell;
                    end
                end
                StDn: begin
                    if (bus.REQ) begin
                        state <= StUp;
                        cnt   <= dwell;
                    end else if (expire) begin
                        en <= en >> 1;
                        // Only EN[0] left: this edge empties the bank.
                        if (!en[1]) begin
                            state <= StOff;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= dwell;
                        end
                    end else begin
                        cnt <= cnt - DLY_W'(1);
                    end
                end
                default: begin
                    state <= StOff;
                    en    <= '0;
                    iso   <= 1'b1;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.EN   = en;
    assign bus.ISO  = iso;
    assign bus.ACK  = ack;
    assign bus.BUSY = busy;

endmodule

// File: tb/tb_sky130_ef_sc_hd__pwrseq_ctrl.sv
// Bench for the power-switch sequencer: vector table, directed corner
// sequences and a randomized run against a stage-count/event-time model.
module tb_sky130_ef_sc_hd__pwrseq_ctrl;

    localparam int N = 8;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sky130_ef_sc_hd__pwrseq_ctrl_if #(.NSTAGES(N), .DLY_W(W)) bus_if ();

    sky130_ef_sc_hd__pwrseq_ctrl #(.NSTAGES(N), .DLY_W(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: number of powered stages, ramp direction and the
    // absolute edge index at which the next stage event is due.
    int     m_n;
    bit     m_ramp;
    bit     m_up;
    bit     m_on;
    longint m_t;
    longint m_next;

    typedef struct {
        bit           req;
        int           dly;
        int           ncyc;
        logic [N-1:0] en;
        bit           iso;
        bit           ack;
        bit           busy;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] therm(input int n);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_ramp = 1'b0;
        m_up   = 1'b0;
        m_on   = 1'b0;
    endtask

    task automatic model_edge(input bit r, input int dly);
        int d;
        d = (dly == 0) ? 1 : dly;
        m_t++;
        if (m_on) begin
            if (!r) begin
                m_on = 1'b0; m_ramp = 1'b1; m_up = 1'b0; m_next = m_t + d;
            end
        end else if (!m_ramp) begin
            if (r) begin
                m_n = 1; m_ramp = 1'b1; m_up = 1'b1; m_next = m_t + d;
            end
        end else if (m_up) begin
            if (!r) begin
                m_up = 1'b0; m_next = m_t + d;
            end else if (m_t == m_next) begin
                if (m_n < N) begin
                    m_n++; m_next = m_t + d;
                end else begin
                    m_on = 1'b1; m_ramp = 1'b0;
                end
            end
        end else begin
            if (r) begin
                m_up = 1'b1; m_next = m_t + d;
            end else if (m_t == m_next) begin
                m_n--;
                if (m_n == 0) m_ramp = 1'b0;
                else m_next = m_t + d;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".en"}, 32'(bus_if.EN), 32'(therm(m_n)));
        check({tag, ".iso_ack_busy"}, 32'({bus_if.ISO, bus_if.ACK, bus_if.BUSY}),
              32'({~m_on, m_on, m_ramp}));
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] en,
                              input bit iso, input bit ack, input bit busy);
        check({tag, ".EN"}, 32'(bus_if.EN), 32'(en));
        check({tag, ".ISO_ACK_BUSY"}, 32'({bus_if.ISO, bus_if.ACK, bus_if.BUSY}),
              32'({iso, ack, busy}));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge(bus_if.REQ, int'(bus_if.DLY));
        #1;
        check_model(tag);
    endtask

    task automatic steps(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    task automatic add(input bit req, input int dly, input int ncyc, input logic [N-1:0] en,
                       input bit iso, input bit ack, input bit busy);
        vec_t v;
        v.req = req; v.dly = dly; v.ncyc = ncyc; v.en = en;
        v.iso = iso; v.ack = ack; v.busy = busy;
        tbl.push_back(v);
    endtask

    // Asynchronous reset pulse placed between edges; outputs checked before the next edge.
    task automatic async_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        model_reset();
        expect_out(tag, '0, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
    endtask

    initial begin
        int rate;
        logic [N-1:0] hold_en;

        // Full up ramp, full down ramp at DLY=4, then the same at DLY=0.
        add(1, 4, 1,  8'h01, 1, 0, 1);
        add(1, 4, 3,  8'h01, 1, 0, 1);
        add(1, 4, 1,  8'h03, 1, 0, 1);
        add(1, 4, 24, 8'hFF, 1, 0, 1);
        add(1, 4, 3,  8'hFF, 1, 0, 1);
        add(1, 4, 1,  8'hFF, 0, 1, 0);
        add(1, 4, 5,  8'hFF, 0, 1, 0);
        add(0, 4, 1,  8'hFF, 1, 0, 1);
        add(0, 4, 3,  8'hFF, 1, 0, 1);
        add(0, 4, 1,  8'h7F, 1, 0, 1);
        add(0, 4, 27, 8'h01, 1, 0, 1);
        add(0, 4, 1,  8'h00, 1, 0, 0);
        add(0, 4, 3,  8'h00, 1, 0, 0);
        add(1, 0, 1,  8'h01, 1, 0, 1);
        add(1, 0, 6,  8'h7F, 1, 0, 1);
        add(1, 0, 1,  8'hFF, 1, 0, 1);
        add(1, 0, 1,  8'hFF, 0, 1, 0);
        add(0, 0, 1,  8'hFF, 1, 0, 1);
        add(0, 0, 7,  8'h01, 1, 0, 1);
        add(0, 0, 1,  8'h00, 1, 0, 0);

        rst        = 1'b1;
        bus_if.REQ = 1'b0;
        bus_if.DLY = W'(4);
        m_t        = 0;
        m_next     = 0;
        model_reset();
        #2;
        expect_out("reset", '0, 1'b1, 1'b0, 1'b0);
        #10 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus_if.REQ = tbl[i].req;
            bus_if.DLY = W'(tbl[i].dly);
            steps(tbl[i].ncyc, "tbl");
            expect_out($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].iso, tbl[i].ack, tbl[i].busy);
        end

        // DLY changed mid-dwell only affects the next reload.
        bus_if.REQ = 1'b1; bus_if.DLY = W'(4);
        step("dlychg");
        bus_if.DLY = W'(2);
        steps(3, "dlychg");
        expect_out("dlychg.e3", 8'h01, 1, 0, 1);
        step("dlychg");
        expect_out("dlychg.e4", 8'h03, 1, 0, 1);
        step("dlychg");
        expect_out("dlychg.e5", 8'h03, 1, 0, 1);
        step("dlychg");
        expect_out("dlychg.e6", 8'h07, 1, 0, 1);
        bus_if.REQ = 1'b0;
        steps(40, "dlychg.off");
        expect_out("dlychg.off", 8'h00, 1, 0, 0);

        // Abort during ramp-up at edge 10.
        bus_if.REQ = 1'b1; bus_if.DLY = W'(4);
        steps(10, "abort_up");
        bus_if.REQ = 1'b0;
        step("abort_up");
        expect_out("abort_up.e10", 8'h07, 1, 0, 1);
        steps(4, "abort_up");
        expect_out("abort_up.e14", 8'h03, 1, 0, 1);
        steps(4, "abort_up");
        expect_out("abort_up.e18", 8'h01, 1, 0, 1);
        steps(4, "abort_up");
        expect_out("abort_up.e22", 8'h00, 1, 0, 0);

        // Abort during ramp-down at u+6, then fast toggling mid-ramp.
        bus_if.REQ = 1'b1;
        steps(33, "abort_dn.up");
        expect_out("abort_dn.on", 8'hFF, 0, 1, 0);
        bus_if.REQ = 1'b0;
        steps(5, "abort_dn");
        expect_out("abort_dn.u4", 8'h7F, 1, 0, 1);
        step("abort_dn");
        bus_if.REQ = 1'b1;
        step("abort_dn");
        expect_out("abort_dn.u6", 8'h7F, 1, 0, 1);
        steps(4, "abort_dn");
        expect_out("abort_dn.u10", 8'hFF, 1, 0, 1);
        steps(3, "abort_dn");
        expect_out("abort_dn.u13", 8'hFF, 1, 0, 1);
        step("abort_dn");
        expect_out("abort_dn.u14", 8'hFF, 0, 1, 0);
        bus_if.REQ = 1'b0;
        steps(10, "toggle.pre");
        expect_out("toggle.pre", 8'h3F, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            bus_if.REQ = ~bus_if.REQ;
            step("toggle");
            check("toggle.en_const", 32'(bus_if.EN), 32'h3F);
        end
        bus_if.REQ = 1'b0;
        steps(40, "toggle.off");
        expect_out("toggle.off", 8'h00, 1, 0, 0);

        // Asynchronous reset mid-UP with REQ held high through release.
        bus_if.REQ = 1'b1;
        steps(10, "rst_mid");
        expect_out("rst_mid.pre", 8'h07, 1, 0, 1);
        async_reset("rst_mid.async");
        step("rst_mid");
        expect_out("rst_mid.restart", 8'h01, 1, 0, 1);

        // Randomized run with varying reversal rates, dwell values and resets.
        for (int seg = 0; seg < 8; seg++) begin
            rate = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 10 : 50);
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, rate - 1) == 0) bus_if.REQ = ~bus_if.REQ;
                if ($urandom_range(0, 19) == 0) bus_if.DLY = W'($urandom_range(0, 3));
                if ($urandom_range(0, 299) == 0) async_reset("rand.rst");
                step("rand");
            end
        end

        // Reversal storm after the random run must leave EN untouched.
        bus_if.REQ = 1'b1; bus_if.DLY = W'(3);
        steps(80, "storm.pre");
        bus_if.REQ = 1'b0;
        steps(7, "storm.pre");
        hold_en = therm(m_n);
        for (int i = 0; i < 10; i++) begin
            bus_if.REQ = ~bus_if.REQ;
            step("storm");
            check("storm.en_const", 32'(bus_if.EN), 32'(hold_en));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sky130_ef_sc_hd__pwrseq_ctrl.md
Name: sky130_ef_sc_hd__pwrseq_ctrl

Overview:
Staged power-switch sequencer for switchable fill/decap regions. It enables a bank of header switch segments one at a time to limit inrush current, and disables them in reverse order. It asserts isolation whenever the region is not fully powered and acknowledges full-on to the requester. It sits between the block power manager (REQ/ACK) and the switch-segment enable nets.

Parameters:
NSTAGES, 8, number of switch segments; legal range 2..32
DLY_W, 8, width of the per-stage dwell input DLY

Ports:
CLK  input  1  clock; all state changes on the rising edge
RESET  input  1  asynchronous, active-high reset
REQ  input  1  level request: 1 = power up / stay on, 0 = power down / stay off
DLY  input  DLY_W  dwell in cycles between stage events; 0 is treated as 1
EN  output  NSTAGES  segment enables, thermometer coded, EN[0] lowest
ISO  output  1  isolation enable; 1 in every state except ON
ACK  output  1  region fully powered and isolation released
BUSY  output  1  ramp in progress (state UP or DN)

Behaviour:
- All outputs are registered. D = max(DLY,1), sampled at every dwell-counter reload. Changes to DLY mid-dwell have no effect until the next reload.
- Reset (async assert; release takes effect at the next CLK edge):
  - state OFF, EN=0, ISO=1, ACK=0, BUSY=0, dwell counter 0.
  - RESET asserted mid-ramp or in ON forces these values immediately, with no reverse sequencing.
- States: OFF, UP, DN, ON.
- OFF: on an edge where REQ=1, go to UP. EN[0]=1, BUSY=1, counter loaded with D.
- UP: the counter decrements each cycle. At expiry (counter reaches 1 on an edge):
  - if EN is not all-ones, set the next EN bit and reload D;
  - if EN is all-ones, go to ON: ACK=1, ISO=0, BUSY=0.
  - Result: with REQ held from edge t, EN[k] rises at edge t+k·D, and ACK rises and ISO falls at edge t+NSTAGES·D.
- ON: EN all-ones, ACK=1, ISO=0. On an edge where REQ=0, go to DN: ISO=1, ACK=0, BUSY=1, counter loaded with D, EN unchanged.
- DN: at expiry, clear the highest set EN bit and reload D. If EN becomes 0, go to OFF on the same edge and BUSY=0.
  - With REQ low from edge u in ON, EN[NSTAGES-1] falls at u+D and EN=0 at u+NSTAGES·D.
- Abort UP: if REQ=0 on any UP edge (including an expiry edge), go to DN.
  - Direction wins over stage add: no bit is added on that edge.
  - EN holds, counter reloads D, ISO stays 1.
- Abort DN: if REQ=1 on any DN edge, go to UP.
  - No bit is removed on that edge.
  - Counter reloads D, ISO stays 1, ACK stays 0.
  - If EN is already all-ones, the next expiry goes directly to ON.
- ISO never falls before all EN bits are 1 and a full dwell has elapsed. ISO rises on the same edge ACK falls, before any EN bit clears.
- EN only changes by one bit per event, always keeping thermometer form. No state sets and clears bits on the same edge.
- REQ toggling every cycle causes no EN change (dwell restarts on every reversal).

Test Plan:
1. Reset, NSTAGES=8, DLY=4, REQ rises at edge 0 -> EN[k] rises at edge 4k (EN=8'hFF at edge 28); ACK=1 and ISO=0 at edge 32; BUSY low at edge 32.
2. From ON, REQ falls at edge u, DLY=4 -> same edge ISO=1 and ACK=0; EN goes 8'h7F at u+4, ... 8'h00 at u+32; state OFF and BUSY=0 at u+32.
3. DLY=0 ramp-up -> one stage per cycle: EN=8'hFF 7 edges after the request, ACK 8 edges after it. DLY changed 4->2 mid-ramp -> new spacing starts at the next reload only.
4. REQ drops at edge 10 of a DLY=4 ramp (EN=8'h07) -> DN entered at edge 10, EN=8'h03 at 14, 8'h01 at 18, 8'h00 at 22; ACK never asserts and ISO stays 1.
5. REQ reasserts at edge u+6 during ramp-down (EN=8'h7F) -> UP, EN=8'hFF at u+10, ACK at u+14. REQ toggled every cycle for 20 cycles -> EN constant.
6. RESET asserted asynchronously mid-UP (between edges) -> EN=0, ISO=1, ACK=0, BUSY=0 immediately. REQ held high through reset release -> ramp restarts with EN[0] at the first edge after release.
